// File: rtl/wfq_vt_sched.sv
// wfq_vt_sched -- weighted-fair queue scheduler built on per-queue
// virtual-time (stride) counters.
//
// Each queue q owns a counter cnt[q]. Among the ready queues, the one with
// the smallest counter is offered; ties go to the lowest index. When the
// offer is accepted, the winner's counter advances by its weight. A small
// weight therefore wins proportionally more often. The counters are kept
// inside CNT_WIDTH bits by clearing their MSB once every ready counter has
// it set.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   wfq_weight     : packed per-queue weights, queue q at [q*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//                    (a weight of 0 counts as 1)
//   wfq_rdy        : per-queue "has data" flags
//   wfq_sch_en     : scheduling enable (only gates new offers)
//   wfq_winner_ack : consumer accepts the offered winner
//   wfq_winner_vld : registered offer-valid flag
//   wfq_winner     : registered index of the offered queue
//
// Optional feature: define WFQ_VT_SCHED_STRICT_Q0_EN to make queue 0 strict
// priority. In that mode queue 0 wins whenever it is ready. Its grants leave
// all virtual-time state untouched. Queues 1..N-1 share the WFQ scheme among
// themselves.

module wfq_vt_sched #(
  parameter int QUEUE_NUM       = 4,
  parameter int QUEUE_NUM_WIDTH = $clog2(QUEUE_NUM),
  parameter int WEIGHT_WIDTH    = 7,
  parameter int CNT_WIDTH       = WEIGHT_WIDTH + 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [QUEUE_NUM*WEIGHT_WIDTH-1:0] wfq_weight,
  input  logic [QUEUE_NUM-1:0]              wfq_rdy,
  input  logic                              wfq_sch_en,
  input  logic                              wfq_winner_ack,
  output logic                              wfq_winner_vld,
  output logic [QUEUE_NUM_WIDTH-1:0]        wfq_winner
);

  localparam int MSB = CNT_WIDTH - 1;

`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
  // Queue 0 sits outside the virtual-time scheme.
  localparam int FIRST_WFQ = 1;
`else
  localparam int FIRST_WFQ = 0;
`endif

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t                     state_reg, state_next;
  logic [CNT_WIDTH-1:0]       cnt_reg  [QUEUE_NUM];
  logic [CNT_WIDTH-1:0]       cnt_next [QUEUE_NUM];
  logic [CNT_WIDTH-1:0]       vtime_reg, vtime_next;
  logic [QUEUE_NUM-1:0]       rdy_q_reg;
  logic [CNT_WIDTH-1:0]       stride   [QUEUE_NUM];

  logic                       sel_found;
  logic [QUEUE_NUM_WIDTH-1:0] sel_idx;
  logic [CNT_WIDTH-1:0]       sel_cnt;
  logic                       grant;
  logic                       grant_wfq;
  logic                       any_rdy;
  logic                       all_hi;
  logic                       renorm;

  // Per-queue stride: the weight zero-extended to counter width, with 0
  // promoted to 1 so a misconfigured queue still makes progress.
  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_NUM; gi++) begin : g_stride
      logic [WEIGHT_WIDTH-1:0] w_raw;
      assign w_raw      = wfq_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign stride[gi] = (w_raw == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1}
                                        : {{(CNT_WIDTH-WEIGHT_WIDTH){1'b0}}, w_raw};
    end
  endgenerate

  // Minimum-counter selection over the ready queues. The ascending scan
  // with a strict '<' keeps the lowest index on ties.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_cnt   = '0;
    for (int q = FIRST_WFQ; q < QUEUE_NUM; q++) begin
      if (wfq_rdy[q] && (!sel_found || (cnt_reg[q] < sel_cnt))) begin
        sel_found = 1'b1;
        sel_idx   = QUEUE_NUM_WIDTH'(q);
        sel_cnt   = cnt_reg[q];
      end
    end
`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
    if (wfq_rdy[0]) begin
      sel_idx = '0;
    end
`endif
  end

  assign grant = (state_reg == OFFER) && wfq_winner_ack;

`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
  assign grant_wfq = grant && (wfq_winner != '0);
`else
  assign grant_wfq = grant;
`endif

  // FSM next state. Ack beats a same-cycle rdy drop. Withdrawal happens only
  // when the offered queue loses its data; sch_en never cancels an offer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (wfq_sch_en && (|wfq_rdy)) begin
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (wfq_winner_ack || !wfq_rdy[wfq_winner]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. The flag decodes the state flop directly, so it is registered.
  always_comb begin
    wfq_winner_vld = (state_reg == OFFER);
  end

  // Virtual-time bookkeeping.
  always_comb begin
    vtime_next = vtime_reg;
    any_rdy    = 1'b0;
    all_hi     = 1'b1;
    renorm     = 1'b0;
    for (int q = 0; q < QUEUE_NUM; q++) begin
      cnt_next[q] = cnt_reg[q];
    end

    // A queue that just became ready is pulled up to the current virtual
    // time. This keeps it from cashing in credit it earned while idle.
    for (int q = FIRST_WFQ; q < QUEUE_NUM; q++) begin
      if (wfq_rdy[q] && !rdy_q_reg[q] && (cnt_reg[q] < vtime_reg)) begin
        cnt_next[q] = vtime_reg;
      end
    end

    // A grant overrides any late-join update to the same queue.
    if (grant_wfq) begin
      vtime_next           = cnt_reg[wfq_winner];
      cnt_next[wfq_winner] = cnt_reg[wfq_winner] + stride[wfq_winner];

      // Renormalise once every ready counter has crossed into the upper
      // half. Idle counters in the lower half are stale and collapse to 0.
      for (int q = FIRST_WFQ; q < QUEUE_NUM; q++) begin
        if (wfq_rdy[q]) begin
          any_rdy = 1'b1;
          if (!cnt_next[q][MSB]) begin
            all_hi = 1'b0;
          end
        end
      end
      renorm = any_rdy && all_hi;

      if (renorm) begin
        for (int q = FIRST_WFQ; q < QUEUE_NUM; q++) begin
          cnt_next[q] = cnt_next[q][MSB] ? {1'b0, cnt_next[q][MSB-1:0]} : '0;
        end
        vtime_next[MSB] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vtime_reg <= '0;
      rdy_q_reg <= '0;
      for (int q = 0; q < QUEUE_NUM; q++) begin
        cnt_reg[q] <= '0;
      end
    end else begin
      vtime_reg <= vtime_next;
      rdy_q_reg <= wfq_rdy;
      for (int q = 0; q < QUEUE_NUM; q++) begin
        cnt_reg[q] <= cnt_next[q];
      end
    end
  end

  // The winner index is loaded only when a new offer starts. It stays
  // stable for as long as the offer is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wfq_winner <= '0;
    end else if ((state_reg == IDLE) && (state_next == OFFER)) begin
      wfq_winner <= sel_idx;
    end
  end

endmodule

// File: tb/tb_wfq_vt_sched.sv
// Self-checking bench for wfq_vt_sched.
// The main instance (default parameters) is compared on every cycle against
// a queue/array model. A second, narrow instance (WEIGHT_WIDTH=3,
// CNT_WIDTH=5) covers counter wrap.

module tb_wfq_vt_sched;

  localparam int QN   = 4;
  localparam int WW   = 7;
  localparam int CW   = WW + 2;
  localparam int HALF = 1 << (CW - 1);
  localparam int CMOD = 1 << CW;

`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
  localparam int FW = 1;
`else
  localparam int FW = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [QN*WW-1:0] wfq_weight = '0;
  logic [QN-1:0]   wfq_rdy = '0;
  logic            wfq_sch_en = 1'b0;
  logic            wfq_winner_ack = 1'b0;
  logic            wfq_winner_vld;
  logic [1:0]      wfq_winner;

  logic [11:0]     w_weight = {4{3'd7}};
  logic [3:0]      w_rdy = 4'hF;
  logic            w_sch_en = 1'b0;
  logic            w_ack = 1'b0;
  logic            w_vld;
  logic [1:0]      w_win;

  int n_checks = 0;
  int n_errors = 0;
  int dut_log[$];

  always #5 clk = ~clk;

  wfq_vt_sched #(.QUEUE_NUM(QN), .WEIGHT_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .wfq_weight(wfq_weight), .wfq_rdy(wfq_rdy),
    .wfq_sch_en(wfq_sch_en), .wfq_winner_ack(wfq_winner_ack),
    .wfq_winner_vld(wfq_winner_vld), .wfq_winner(wfq_winner)
  );

  wfq_vt_sched #(.QUEUE_NUM(4), .WEIGHT_WIDTH(3), .CNT_WIDTH(5)) dut_w (
    .clk(clk), .rst(rst), .wfq_weight(w_weight), .wfq_rdy(w_rdy),
    .wfq_sch_en(w_sch_en), .wfq_winner_ack(w_ack),
    .wfq_winner_vld(w_vld), .wfq_winner(w_win)
  );

  // ---------------- behavioural model ----------------
  int          m_cnt [QN] = '{default: 0};
  int          m_vtime = 0;
  logic [QN-1:0] m_prev = '0;
  bit          m_vld = 1'b0;
  int          m_win = 0;

  function automatic int model_pick();
    int best = -1;
`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
    if (wfq_rdy[0]) return 0;
`endif
    for (int q = FW; q < QN; q++) begin
      if (wfq_rdy[q] && (best < 0 || m_cnt[q] < m_cnt[best])) best = q;
    end
    return (best < 0) ? 0 : best;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < QN; q++) m_cnt[q] = 0;
    m_vtime = 0;
    m_prev  = '0;
    m_vld   = 1'b0;
    m_win   = 0;
  endtask

  task automatic model_step();
    int nc [QN];
    int nv;
    int w;
    bit g, wd, any, hi;
    nv = m_vtime;
    g  = m_vld && wfq_winner_ack;
    wd = m_vld && !wfq_winner_ack && !wfq_rdy[m_win];
    for (int q = 0; q < QN; q++) nc[q] = m_cnt[q];
    for (int q = FW; q < QN; q++)
      if (wfq_rdy[q] && !m_prev[q] && m_vtime > m_cnt[q]) nc[q] = m_vtime;
    if (g && m_win >= FW) begin
      w = int'(wfq_weight[m_win*WW +: WW]);
      if (w == 0) w = 1;
      nv = m_cnt[m_win];
      nc[m_win] = (m_cnt[m_win] + w) % CMOD;
      any = 1'b0;
      hi  = 1'b1;
      for (int q = FW; q < QN; q++) begin
        if (wfq_rdy[q]) begin
          any = 1'b1;
          if (nc[q] < HALF) hi = 1'b0;
        end
      end
      if (any && hi) begin
        for (int q = FW; q < QN; q++) nc[q] = (nc[q] >= HALF) ? nc[q] - HALF : 0;
        nv = nv % HALF;
      end
    end
    if (!m_vld) begin
      if (wfq_sch_en && wfq_rdy != '0) begin
        m_vld = 1'b1;
        m_win = model_pick();
      end
    end else if (g || wd) begin
      m_vld = 1'b0;
    end
    for (int q = 0; q < QN; q++) m_cnt[q] = nc[q];
    m_vtime = nv;
    m_prev  = wfq_rdy;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (wfq_winner_vld !== m_vld) begin
        n_errors++;
        $display("FAIL model_vld t=%0t got=%0b expected=%0b", $time, wfq_winner_vld, m_vld);
      end
      if (m_vld) begin
        n_checks++;
        if (int'(wfq_winner) != m_win) begin
          n_errors++;
          $display("FAIL model_winner t=%0t got=%0d expected=%0d", $time, wfq_winner, m_win);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_weights(input int a, input int b, input int c, input int d);
    wfq_weight = {WW'(d), WW'(c), WW'(b), WW'(a)};
  endtask

  task automatic do_reset();
    wfq_rdy        = '0;
    wfq_sch_en     = 1'b0;
    wfq_winner_ack = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_offer(input string name);
    int c = 0;
    while (!wfq_winner_vld && c < 20) begin
      tick();
      c++;
    end
    check({name, "_offer_seen"}, int'(wfq_winner_vld), 1);
  endtask

  // Acks every offer until n grants are logged (bounded by a cycle budget).
  task automatic run_grants(input int n);
    int got = 0;
    int c = 0;
    dut_log.delete();
    while (got < n && c < 4*n + 20) begin
      tick();
      c++;
      if (wfq_winner_vld) begin
        wfq_winner_ack = 1'b1;
        dut_log.push_back(int'(wfq_winner));
        $display("grant #%0d queue=%0d t=%0t", got, wfq_winner, $time);
        got++;
      end else begin
        wfq_winner_ack = 1'b0;
      end
    end
    tick();
    wfq_winner_ack = 1'b0;
    check("grant_budget", got, n);
  endtask

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_seq [6];
    int exp0, exp1, bad, n, c;
    int wcnt [4];

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_vld", int'(wfq_winner_vld), 0);
    check("reset_winner", int'(wfq_winner), 0);

    // Reset in the middle of an offer
    do_reset();
    set_weights(1, 1, 1, 1);
    wfq_rdy    = 4'hF;
    wfq_sch_en = 1'b1;
    wait_offer("rst");
    rst = 1'b1;
    #1;
    check("rst_async_vld", int'(wfq_winner_vld), 0);
    tick();
    tick();
    rst = 1'b0;
    wait_offer("rst_re");
    check("rst_first_q0", int'(wfq_winner), 0);

    // Weight ratio 1:2
    do_reset();
    set_weights(1, 2, 0, 0);
    wfq_rdy    = 4'b0011;
    wfq_sch_en = 1'b1;
    run_grants(300);
`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
    exp_seq = '{0, 0, 0, 0, 0, 0};
    exp0 = 300;
    exp1 = 0;
`else
    exp_seq = '{0, 1, 0, 0, 1, 0};
    exp0 = 200;
    exp1 = 100;
`endif
    for (int i = 0; i < 6; i++) check($sformatf("ratio_seq%0d", i), dut_log[i], exp_seq[i]);
    n = 0;
    c = 0;
    foreach (dut_log[i]) begin
      if (dut_log[i] == 0) n++;
      if (dut_log[i] == 1) c++;
    end
    check("ratio_total_q0", n, exp0);
    check("ratio_total_q1", c, exp1);

    // Withdrawal of a pending offer
    do_reset();
    set_weights(1, 1, 1, 1);
    wfq_rdy    = 4'b0100;
    wfq_sch_en = 1'b1;
    wait_offer("wd");
    check("wd_winner_q2", int'(wfq_winner), 2);
    wfq_rdy = 4'b0011;
    tick();
    check("wd_vld_drop", int'(wfq_winner_vld), 0);
    wait_offer("wd_next");
    check("wd_next_q0", int'(wfq_winner), 0);
    wfq_winner_ack = 1'b1;
    tick();
    wfq_winner_ack = 1'b0;

    // Late joiner: q1/q2 build up virtual time, then q3 becomes ready
    do_reset();
    set_weights(1, 1, 1, 1);
    wfq_rdy    = 4'b0110;
    wfq_sch_en = 1'b1;
    run_grants(50);
    wfq_sch_en = 1'b0;
    tick();
    tick();
    wfq_rdy = 4'b1110;
    tick();
    wfq_sch_en = 1'b1;
    run_grants(12);
    check("late_first_q3", dut_log[0], 3);
    bad = 0;
    for (int i = 1; i < 12; i++) if (dut_log[i] == 3 && dut_log[i-1] == 3) bad++;
    check("late_no_repeat", bad, 0);

    // Equal weights on q0/q1, then q0 drops out
    do_reset();
    set_weights(1, 1, 1, 1);
    wfq_rdy    = 4'b0011;
    wfq_sch_en = 1'b1;
    run_grants(8);
    for (int i = 0; i < 8; i++) begin
`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
      check($sformatf("pair_seq%0d", i), dut_log[i], 0);
`else
      check($sformatf("pair_seq%0d", i), dut_log[i], i % 2);
`endif
    end
    wfq_rdy = 4'b0010;
    run_grants(3);
    for (int i = 0; i < 3; i++) check($sformatf("q1_only%0d", i), dut_log[i], 1);

    // Randomised traffic, checked cycle by cycle against the model
    do_reset();
    for (int q = 0; q < QN; q++) wfq_weight[q*WW +: WW] = WW'($urandom_range(1, 127));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int q = 0; q < QN; q++) if ($urandom_range(0, 7) == 0) wfq_rdy[q] = ~wfq_rdy[q];
      wfq_sch_en     = ($urandom_range(0, 9) != 0);
      wfq_winner_ack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 49) == 0) begin
        for (int q = 0; q < QN; q++)
          wfq_weight[q*WW +: WW] = ($urandom_range(0, 3) == 0) ? '0 : WW'($urandom_range(1, 127));
      end
    end
    do_reset();

    // Counter wrap on the narrow instance: weights 7 in 5-bit counters
    w_sch_en = 1'b1;
    n = 0;
    c = 0;
    for (int q = 0; q < 4; q++) wcnt[q] = 0;
    while (n < 1000 && c < 5000) begin
      tick();
      c++;
      if (w_vld) begin
        w_ack = 1'b1;
`ifdef WFQ_VT_SCHED_STRICT_Q0_EN
        check("wrap_order", int'(w_win), 0);
`else
        check("wrap_order", int'(w_win), n % 4);
`endif
        wcnt[w_win]++;
        n++;
      end else begin
        w_ack = 1'b0;
      end
    end
    tick();
    w_ack    = 1'b0;
    w_sch_en = 1'b0;
    check("wrap_grants", n, 1000);
`ifndef WFQ_VT_SCHED_STRICT_Q0_EN
    exp0 = wcnt[0];
    exp1 = wcnt[0];
    for (int q = 1; q < 4; q++) begin
      if (wcnt[q] < exp0) exp0 = wcnt[q];
      if (wcnt[q] > exp1) exp1 = wcnt[q];
    end
    check("wrap_balance_le1", (exp1 - exp0 <= 1) ? 1 : 0, 1);
`endif
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
